// File: rtl/aes_pkg.sv
// Shared types for the AES CBC controller and the core it drives.
package aes_pkg;

   localparam int AES_BLK_W = 128;
   localparam int AES_KEY_W = 256;

   typedef logic [AES_BLK_W-1:0] aes_block_t;
   typedef logic [AES_KEY_W-1:0] aes_key_t;

   typedef enum logic [1:0] {
      AES128 = 2'd0,
      AES192 = 2'd1,
      AES256 = 2'd2
   } aes_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } cbc_state_e;

endpackage

// File: rtl/aes_cbc_ctrl.sv
// CBC chaining front end for one AES core: start/done initiator, one block in flight,
// valid/ready streams on both sides and a sticky error on core timeout.
module aes_cbc_ctrl
   import aes_pkg::*;
#(
   parameter int BLK_W   = 128,
   parameter int KEY_W   = 256,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_load,
   input  logic             cfg_enc_dec,
   input  logic [1:0]       cfg_mode,
   input  logic [KEY_W-1:0] cfg_key,
   input  logic [BLK_W-1:0] cfg_iv,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             out_last,
   output logic             err,
   output logic             core_start,
   output logic             core_enc_dec,
   output logic [1:0]       core_mode,
   output logic [KEY_W-1:0] core_key,
   output logic [BLK_W-1:0] core_data_in,
   input  logic [BLK_W-1:0] core_data_out,
   input  logic             core_done
);

   // Counter holds 0..TIMEOUT-1; the last value is the final WAIT cycle allowed.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   cbc_state_e       state_q;
   logic             armed_q;
   logic             dec_q;
   aes_mode_e        mode_q;
   logic [KEY_W-1:0] key_q;
   logic [BLK_W-1:0] chain_q;
   logic [BLK_W-1:0] blk_q;
   logic             last_q;
   logic [BLK_W-1:0] data_in_q;
   logic             start_q;
   logic [CNT_W-1:0] cnt_q;
   logic             out_valid_q;
   logic [BLK_W-1:0] out_data_q;
   logic             out_last_q;
   logic             err_q;

   logic             in_hs;
   logic             timeout_hit;
   logic [BLK_W-1:0] res_d;
   logic [BLK_W-1:0] chain_d;

   assign in_ready    = (state_q == IDLE) & armed_q & ~cfg_load;
   assign in_hs       = in_valid & in_ready;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   // Decrypt un-chains after the core and carries the ciphertext forward;
   // encrypt carries the fresh ciphertext forward unchanged.
   assign res_d   = dec_q ? (core_data_out ^ chain_q) : core_data_out;
   assign chain_d = dec_q ? blk_q : core_data_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         armed_q     <= 1'b0;
         dec_q       <= 1'b0;
         mode_q      <= AES128;
         key_q       <= '0;
         chain_q     <= '0;
         blk_q       <= '0;
         last_q      <= 1'b0;
         data_in_q   <= '0;
         start_q     <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cfg_load) begin
                  dec_q   <= cfg_enc_dec;
                  mode_q  <= aes_mode_e'(cfg_mode);
                  key_q   <= cfg_key;
                  chain_q <= cfg_iv;
                  armed_q <= 1'b1;
               end else if (in_hs) begin
                  blk_q     <= in_data;
                  last_q    <= in_last;
                  data_in_q <= dec_q ? in_data : (in_data ^ chain_q);
                  start_q   <= 1'b1;
                  state_q   <= START;
               end
            end
            START: begin
               start_q <= 1'b0;
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (core_done) begin
                  out_data_q  <= res_d;
                  chain_q     <= chain_d;
                  out_last_q  <= last_q;
                  out_valid_q <= 1'b1;
                  state_q     <= OUT;
               end else if (timeout_hit) begin
                  err_q   <= 1'b1;
                  armed_q <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (last_q) begin
                     armed_q <= 1'b0;
                  end
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_last     = out_last_q;
   assign err          = err_q;
   assign core_start   = start_q;
   assign core_enc_dec = dec_q;
   assign core_mode    = mode_q;
   assign core_key     = key_q;
   assign core_data_in = data_in_q;

endmodule
